// File: rtl/axi4_master_burst_read.sv
// AXI4 read master: fetches one cache line per request as a single burst and accumulates response faults.
// Optional macro CRITICAL_WORD_FIRST_EN selects a WRAP burst that returns the requested word first.

module axi4_mbr_word #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] word_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            word_q <= '0;
        end else if (we_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;
endmodule

module axi4_master_burst_read #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WORDS    = 16
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]             i_addr,
    input  logic                                  i_start_read,
    output logic [BLOCK_WORDS*AXI_DATA_WIDTH-1:0] o_data_block,
    output logic                                  o_access_fault,
    output logic                                  o_done,
    output logic                                  o_busy,
    input  logic                                  AR_READY,
    output logic                                  AR_VALID,
    output logic [AXI_ADDR_WIDTH-1:0]             AR_ADDR,
    output logic [7:0]                            AR_LEN,
    output logic [2:0]                            AR_SIZE,
    output logic [1:0]                            AR_BURST,
    output logic [2:0]                            AR_PROT,
    input  logic [AXI_DATA_WIDTH-1:0]             R_DATA,
    input  logic [1:0]                            R_RESP,
    input  logic                                  R_LAST,
    input  logic                                  R_VALID,
    output logic                                  R_READY
);
    localparam int BYTE_OFF = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IDX_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int CNT_W    = $clog2(BLOCK_WORDS + 1);

    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_BYTES =
        AXI_ADDR_WIDTH'(BLOCK_WORDS * (AXI_DATA_WIDTH / 8));
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK  =
        AXI_ADDR_WIDTH'((AXI_DATA_WIDTH / 8) - 1);
    localparam logic [CNT_W-1:0]          LAST_CNT   = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0]          LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_e;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [IDX_W-1:0]          idx_q, start_idx_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      fault_q;
    logic                      beat_fire, last_beat, beat_fault;
    logic                      unused_resp0;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] BURST_TYPE = 2'b10;
    // Slave returns the addressed beat first; land it in its own slot and wrap.
    assign ar_addr_d   = i_addr & ~BEAT_MASK;
    assign start_idx_d = i_addr[BYTE_OFF +: IDX_W];
`else
    localparam logic [1:0] BURST_TYPE = 2'b01;
    // Modulo form keeps non-power-of-two lines correct; reduces to a mask otherwise.
    assign ar_addr_d   = i_addr - (i_addr % LINE_BYTES);
    assign start_idx_d = '0;
`endif

    assign beat_fire  = R_VALID && (state_q == S_DATA);
    assign last_beat  = (cnt_q == LAST_CNT);
    // Termination is by count; R_LAST only feeds the fault flag.
    assign beat_fault = R_RESP[1] || (R_LAST != last_beat);
    assign unused_resp0 = R_RESP[0];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            ar_addr_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start_read) begin
                        state_q   <= S_ADDR;
                        ar_addr_q <= ar_addr_d;
                        idx_q     <= start_idx_d;
                        cnt_q     <= '0;
                        fault_q   <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (AR_READY) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (R_VALID) begin
                        cnt_q <= cnt_q + 1'b1;
                        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        if (beat_fault) begin
                            fault_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [BLOCK_WORDS-1:0][AXI_DATA_WIDTH-1:0] words;

    for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_word
        axi4_mbr_word #(.W(AXI_DATA_WIDTH)) u_word (
            .clk    (clk),
            .arst_n (arst_n),
            .we_i   (beat_fire && (idx_q == IDX_W'(k))),
            .d_i    (R_DATA),
            .q_o    (words[k])
        );
    end

    assign o_data_block   = words;
    assign o_access_fault = fault_q;
    assign o_done         = (state_q == S_DONE);
    assign o_busy         = (state_q != S_IDLE);

    assign AR_VALID = (state_q == S_ADDR);
    assign R_READY  = (state_q == S_DATA);
    assign AR_ADDR  = ar_addr_q;
    assign AR_LEN   = 8'(BLOCK_WORDS - 1);
    assign AR_SIZE  = 3'(BYTE_OFF);
    assign AR_BURST = BURST_TYPE;
    assign AR_PROT  = 3'b100;
endmodule

// File: tb/tb_axi4_master_burst_read.sv
// Scoreboard bench for axi4_master_burst_read; honours CRITICAL_WORD_FIRST_EN like the RTL.

module tb_axi4_master_burst_read;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int BW = 16;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             arst_n;
    logic [AW-1:0]    i_addr;
    logic             i_start_read;
    logic [BW*DW-1:0] o_data_block;
    logic             o_access_fault, o_done, o_busy;
    logic             AR_READY, AR_VALID;
    logic [AW-1:0]    AR_ADDR;
    logic [7:0]       AR_LEN;
    logic [2:0]       AR_SIZE, AR_PROT;
    logic [1:0]       AR_BURST;
    logic [DW-1:0]    R_DATA;
    logic [1:0]       R_RESP;
    logic             R_LAST, R_VALID, R_READY;

    axi4_master_burst_read #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .BLOCK_WORDS    (BW)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_addr         (i_addr),
        .i_start_read   (i_start_read),
        .o_data_block   (o_data_block),
        .o_access_fault (o_access_fault),
        .o_done         (o_done),
        .o_busy         (o_busy),
        .AR_READY       (AR_READY),
        .AR_VALID       (AR_VALID),
        .AR_ADDR        (AR_ADDR),
        .AR_LEN         (AR_LEN),
        .AR_SIZE        (AR_SIZE),
        .AR_BURST       (AR_BURST),
        .AR_PROT        (AR_PROT),
        .R_DATA         (R_DATA),
        .R_RESP         (R_RESP),
        .R_LAST         (R_LAST),
        .R_VALID        (R_VALID),
        .R_READY        (R_READY)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (o_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ar_valid"}, 64'(AR_VALID), 64'd0);
        chk({tag, "_r_ready"},  64'(R_READY), 64'd0);
        chk({tag, "_ar_addr"},  AR_ADDR, 64'd0);
        chk({tag, "_data_or"},  64'(|o_data_block), 64'd0);
        chk({tag, "_fault"},    64'(o_access_fault), 64'd0);
        chk({tag, "_done"},     64'(o_done), 64'd0);
        chk({tag, "_busy"},     64'(o_busy), 64'd0);
    endtask

    // One line fetch. Beat numbers are 0-based; -1 disables an option.
    task automatic run_line(input logic [AW-1:0] addr, input int stall, input bit gap,
                            input int err_beat, input int early_last, input bit miss_last,
                            input int rst_beat, input int exp_done_cyc,
                            input logic [DW-1:0] base, input bit poke);
        int            t0, b, st, start, guard, dc;
        bit            ph, acc, exp_fault;
        logic [AW-1:0] exp_addr;
        exp_t          e;

        exp_addr  = CWF ? (addr & ~64'h3) : (addr & ~64'h3f);
        start     = CWF ? int'((addr >> 2) & 64'hf) : 0;
        exp_fault = 1'b0;

        @(negedge clk);
        i_addr = addr; i_start_read = 1'b1; AR_READY = (stall == 0); t0 = cyc;
        @(negedge clk);
        i_start_read = 1'b0;
        chk("ar_valid",  64'(AR_VALID), 64'd1);
        chk("ar_addr",   AR_ADDR, exp_addr);
        chk("ar_len",    64'(AR_LEN), 64'd15);
        chk("ar_size",   64'(AR_SIZE), 64'd2);
        chk("ar_burst",  64'(AR_BURST), CWF ? 64'd2 : 64'd1);
        chk("ar_prot",   64'(AR_PROT), 64'd4);
        chk("busy",      64'(o_busy), 64'd1);
        chk("fault_clr", 64'(o_access_fault), 64'd0);

        b = 0; st = 0; ph = 1'b0; guard = 0;
        while (b < BW && guard < 300) begin
            guard++;
            if (b == rst_beat) begin
                arst_n = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                sbq.delete();
                R_VALID = 1'b0; AR_READY = 1'b0;
                @(negedge clk);
                arst_n = 1'b1;
                return;
            end
            if (AR_VALID) begin
                chk("r_ready_in_addr", 64'(R_READY), 64'd0);
                chk("ar_addr_stable",  AR_ADDR, exp_addr);
                if (st < stall) begin
                    AR_READY = 1'b0;
                    st++;
                end else begin
                    AR_READY = 1'b1;
                end
            end else begin
                AR_READY = 1'b0;
            end
            i_start_read = poke && (b == 5);
            if (poke && b == 5) i_addr = 64'hdead_0000;
            R_VALID = gap ? ~ph : 1'b1;
            ph      = ~ph;
            R_DATA  = base + DW'(b);
            R_RESP  = (b == err_beat) ? 2'b10 : 2'b00;
            R_LAST  = (b == BW - 1) ? !miss_last : (b == early_last);
            acc     = R_VALID && R_READY;
            @(posedge clk);
            if (acc) begin
                sbq.push_back('{idx: (start + b) % BW, data: base + DW'(b)});
                if (R_RESP[1] || (R_LAST != (b == BW - 1))) exp_fault = 1'b1;
                b++;
            end
            @(negedge clk);
        end
        i_start_read = 1'b0;
        R_VALID = 1'b0; R_LAST = 1'b0; R_RESP = 2'b00; AR_READY = 1'b0;
        if (guard >= 300) chk("beat_timeout", 64'(b), 64'(BW));

        chk("done",      64'(o_done), 64'd1);
        chk("busy_done", 64'(o_busy), 64'd1);
        if (exp_done_cyc > 0) chk("done_cycle", 64'(cyc - t0), 64'(exp_done_cyc));
        chk("fault",     64'(o_access_fault), 64'(exp_fault));
        chk("beats",     64'(sbq.size()), 64'(BW));
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("word%0d", e.idx), 64'(o_data_block[e.idx*DW +: DW]), 64'(e.data));
        end
        dc = done_cnt;
        @(negedge clk);
        chk("done_pulse",   64'(o_done), 64'd0);
        chk("idle",         64'(o_busy), 64'd0);
        chk("fault_hold",   64'(o_access_fault), 64'(exp_fault));
        chk("ar_addr_hold", AR_ADDR, exp_addr);
        repeat (3) @(negedge clk);
        chk("one_done",     64'(done_cnt - dc), 64'd1);
        chk("no_requeue",   64'(o_busy), 64'd0);
    endtask

    initial begin
        i_addr = '0; i_start_read = 1'b0; AR_READY = 1'b0;
        R_DATA = '0; R_RESP = 2'b00; R_LAST = 1'b0; R_VALID = 1'b0;
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        arst_n = 1'b1;
        @(negedge clk);

        // best case, word k = k in INCR mode
        run_line(64'h1234, 0, 1'b0, -1, -1, 1'b0, -1, 18, 32'h0, 1'b0);
        // AR stall + R_VALID gaps + ignored start in DATA
        run_line(64'h8000_0040, 5, 1'b1, -1, -1, 1'b0, -1, 0, 32'h100, 1'b1);
        // SLVERR on beat 7
        run_line(64'h2008, 0, 1'b0, 7, -1, 1'b0, -1, 0, 32'ha000, 1'b0);
        // early R_LAST on beat 4
        run_line(64'h3010, 0, 1'b0, -1, 4, 1'b0, -1, 0, $urandom(), 1'b0);
        // R_LAST missing on final beat
        run_line(64'h4ffc, 0, 1'b1, -1, -1, 1'b1, -1, 0, $urandom(), 1'b0);
        // clean run between fault runs confirms clear
        run_line(64'h1234, 2, 1'b0, -1, -1, 1'b0, -1, 0, $urandom(), 1'b0);
        // reset mid-burst after 9 beats, then a normal line
        run_line(64'h5000, 0, 1'b0, -1, -1, 1'b0, 9, 0, 32'h55, 1'b0);
        run_line(64'h1234, 0, 1'b0, -1, -1, 1'b0, -1, 18, $urandom(), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
